// File: rtl/pipe_skid_reg.sv
// Two-slot registered pipeline stage (main + skid) with synchronous flush.
// Optional backpressure statistics counter enabled by macro PIPE_SKID_REG_STATS_EN.
module pipe_skid_reg #(
   parameter int PC_BITS   = 32,
   parameter int IR_BITS   = 32,
   parameter int DATA_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 zero,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PC_BITS-1:0]   in_pc,
   input  logic [IR_BITS-1:0]   in_ir,
   input  logic [DATA_BITS-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PC_BITS-1:0]   out_pc,
   output logic [IR_BITS-1:0]   out_ir,
   output logic [DATA_BITS-1:0] out_data,
   output logic [1:0]           occupancy,
   output logic [31:0]          stall_cnt
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   localparam int PW = PC_BITS + IR_BITS + DATA_BITS;

   logic [1:0]    st;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic [PW-1:0] in_pl;
   logic          in_fire;
   logic          out_fire;

   // State encoding equals beat count, so every handshake output is a
   // decode of registered state only.
   assign in_ready  = (st != FULL);
   assign out_valid = (st != EMPTY);
   assign occupancy = st;
   assign {out_pc, out_ir, out_data} = main_q;

   assign in_pl    = {in_pc, in_ir, in_data};
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (zero) begin
         st     <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         case (st)
            EMPTY: begin
               if (in_fire) begin
                  st     <= ONE;
                  main_q <= in_pl;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_pl;
               end else if (in_fire) begin
                  st     <= FULL;
                  skid_q <= in_pl;
               end else if (out_fire) begin
                  st     <= EMPTY;
                  main_q <= '0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  st     <= ONE;
                  main_q <= skid_q;
                  skid_q <= '0;
               end
            end
            default: begin
               st     <= EMPTY;
               main_q <= '0;
               skid_q <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_SKID_REG_STATS_EN
   // Flush deliberately leaves the counter alone; only reset clears it.
   logic [31:0] stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= '0;
      else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
         stall_q <= stall_q + 32'd1;
   end
   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: driver pushes accepted beats, monitor pops on out_fire.
module tb_pipe_skid_reg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        zero = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0, in_ir = '0, in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_ir, out_data;
   logic [1:0]  occupancy;
   logic [31:0] stall_cnt;

   int tests = 0;
   int fails = 0;
   int accepted = 0;
   beat_t q[$];

   pipe_skid_reg dut (
      .clk(clk), .rst_n(rst_n), .zero(zero),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_ir(in_ir), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_ir(out_ir), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic offer(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_ir    = pc ^ 32'h5A5A_0001;
      in_data  = ~pc;
   endtask

   // One clock: record acceptance before the edge, return 1 time unit after it.
   task automatic cyc();
      beat_t b;
      @(negedge clk);
      if (zero) q.delete();
      else if (in_valid && in_ready) begin
         b.pc = in_pc; b.ir = in_ir; b.data = in_data;
         q.push_back(b);
         accepted++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      offer(1'b0, 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) break;
         cyc();
      end
      cyc();
      chk({name, "_queue_empty"}, q.size(), 0);
      chk({name, "_occ0"}, {30'd0, occupancy}, 0);
   endtask

   // Monitor: out_fire at the coming edge means out_* must match the oldest beat.
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && !zero) begin
         tests++;
         if (occupancy > 2'd2) begin
            fails++;
            $display("FAIL occupancy_range: got %0d expected <=2", occupancy);
         end
         if (!out_valid) chk("bubble_ir_zero", out_ir, 32'd0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_beat: got pc %h expected none", out_pc);
            end else begin
               e = q.pop_front();
               chk("out_pc", out_pc, e.pc);
               chk("out_ir", out_ir, e.ir);
               chk("out_data", out_data, e.data);
            end
         end
      end
   end

   initial begin
      // Reset state
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_occ", {30'd0, occupancy}, 0);
      chk("rst_out_ir", out_ir, 0);
      chk("rst_stall", stall_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Streaming with one-cycle latency
      out_ready = 1'b1;
      offer(1'b1, 32'h100); cyc();
      chk("latency_valid", {31'd0, out_valid}, 1);
      chk("latency_pc", out_pc, 32'h100);
      offer(1'b1, 32'h104); cyc();
      offer(1'b1, 32'h108); cyc();
      chk("stream_occ", {30'd0, occupancy}, 1);
      chk("stream_last_pc", out_pc, 32'h108);
      drain("stream");

      // Backpressure: fill both slots, third beat held off
      out_ready = 1'b0;
      offer(1'b1, 32'h200); cyc();
      offer(1'b1, 32'h204); cyc();
      chk("bp_occ2", {30'd0, occupancy}, 2);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      offer(1'b1, 32'h208); cyc();
      chk("bp_hold_occ", {30'd0, occupancy}, 2);
      chk("bp_hold_pc", out_pc, 32'h200);
      out_ready = 1'b1;
      begin
         int a0;
         a0 = accepted;
         for (int i = 0; i < 5 && accepted == a0; i++) cyc();
         chk("bp_208_accepted", accepted - a0, 1);
      end
      drain("bp");

      // Flush from FULL overrides both handshakes
      out_ready = 1'b0;
      offer(1'b1, 32'h300); cyc();
      offer(1'b1, 32'h304); cyc();
      chk("flush_pre_occ", {30'd0, occupancy}, 2);
      out_ready = 1'b1; zero = 1'b1;
      offer(1'b1, 32'h308); cyc();
      zero = 1'b0;
      chk("flush_occ", {30'd0, occupancy}, 0);
      chk("flush_out_ir", out_ir, 0);
      chk("flush_out_valid", {31'd0, out_valid}, 0);
      offer(1'b0, 32'd0); cyc();
      chk("flush_no_beat", {31'd0, out_valid}, 0);

      // Asynchronous reset mid-FULL
      out_ready = 1'b0;
      offer(1'b1, 32'h400); cyc();
      offer(1'b1, 32'h404); cyc();
      offer(1'b0, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
      chk("mid_rst_out_ir", out_ir, 0);
      chk("mid_rst_occ", {30'd0, occupancy}, 0);
      chk("mid_rst_stall", stall_cnt, 0);
      q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Stall statistics
      out_ready = 1'b0;
      offer(1'b1, 32'h500); cyc();
      offer(1'b0, 32'd0);
      repeat (5) cyc();
`ifdef PIPE_SKID_REG_STATS_EN
      chk("stall_5", stall_cnt, 32'd5);
`else
      chk("stall_off", stall_cnt, 32'd0);
`endif
      zero = 1'b1; out_ready = 1'b1; cyc(); zero = 1'b0;
`ifdef PIPE_SKID_REG_STATS_EN
      chk("stall_after_zero", stall_cnt, 32'd5);
`else
      chk("stall_off_after_zero", stall_cnt, 32'd0);
`endif
      chk("stall_zero_occ", {30'd0, occupancy}, 0);

      // Random handshakes, 1000 beats
      begin
         int a0, n;
         a0 = accepted;
         n = 0;
         while (accepted - a0 < 1000 && n < 20000) begin
            offer(1'($urandom_range(0, 1)), 32'h1000 + 32'(accepted - a0) * 4);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
         end
         chk("rand_beats", accepted - a0, 1000);
      end
      drain("rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter PC_BITS, default 32, program-counter field width.
REQ-002 SHALL have parameter IR_BITS, default 32, instruction field width.
REQ-003 SHALL have parameter DATA_BITS, default 32, packed control/data bundle width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port zero  input  1  synchronous flush; empties the stage.
REQ-007 SHALL have port in_valid  input  1  upstream offers a beat.
REQ-008 SHALL have port in_ready  output  1  stage accepts a beat this cycle.
REQ-009 SHALL have ports in_pc / in_ir / in_data  input  PC_BITS / IR_BITS / DATA_BITS  upstream payload.
REQ-010 SHALL have port out_valid  output  1  stage presents a beat.
REQ-011 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-012 SHALL have ports out_pc / out_ir / out_data  output  PC_BITS / IR_BITS / DATA_BITS  presented payload.
REQ-013 SHALL have port occupancy  output  2  number of held beats, 0..2.
REQ-014 SHALL have port stall_cnt  output  32  backpressure cycle counter (see Configuration).

Function
REQ-015 SHALL hold two payload slots: main (drives out_*) and skid; states EMPTY (0 beats), ONE (main valid), FULL (main+skid valid).
REQ-016 SHALL register every output; no combinational path from in_* or out_ready to any output.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; out_valid = 1 in ONE and FULL.
REQ-018 SHALL define in_fire = in_valid & in_ready, out_fire = out_valid & out_ready.
REQ-019 EMPTY: in_fire -> ONE, main <= in payload; else stay.
REQ-020 ONE: in_fire & out_fire -> ONE, main <= in payload; in_fire & !out_fire -> FULL, skid <= in payload; !in_fire & out_fire -> EMPTY; else stay.
REQ-021 FULL: out_fire -> ONE, main <= skid; else stay; in_valid ignored.
REQ-022 SHALL give 1-cycle latency: a beat accepted in EMPTY appears on out_* the next cycle.
REQ-023 SHALL preserve order: beats leave in acceptance order; no beat is dropped or duplicated.
REQ-024 SHALL zero main payload on any transition to EMPTY, so out_ir = 0 (nop bubble) whenever out_valid = 0.
REQ-025 SHALL, when zero = 1 at an edge, go to EMPTY and zero both slots, overriding in_fire and out_fire in that cycle.
REQ-026 SHALL drive occupancy = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force EMPTY: out_valid 0, in_ready 1, out_pc/out_ir/out_data 0, skid 0, occupancy 0, stall_cnt 0.
REQ-028 SHALL treat reset asserted mid-transfer as discarding all held beats; first edge after rst_n rises behaves as EMPTY.

Configuration
REQ-029 SHALL support macro PIPE_SKID_REG_STATS_EN.
REQ-030 With PIPE_SKID_REG_STATS_EN defined, stall_cnt SHALL increment by 1 each cycle out_valid & !out_ready, saturating at 32'hFFFF_FFFF; zero does not clear it; only rst_n does.
REQ-031 Without PIPE_SKID_REG_STATS_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-032 Reset: rst_n=0 mid-FULL -> same-cycle out_valid=0, in_ready=1, out_ir=0, occupancy=0.
REQ-033 Streaming: out_ready=1, in_valid=1 with in_pc=0x100,0x104,0x108 on 3 edges -> out_pc 0x100,0x104,0x108 on following edges, occupancy 1.
REQ-034 Backpressure: out_ready=0, send 0x200,0x204 -> occupancy 2, in_ready=0, 0x208 held off; raise out_ready -> 0x200,0x204,0x208 in order, none lost.
REQ-035 Flush: FULL, zero=1 with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_ir=0, out_valid=0, offered beat not accepted.
REQ-036 Stats (macro defined): out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; zero pulse leaves 5; macro undefined -> stall_cnt stays 0.
REQ-037 Randomised in_valid/out_ready 1000 beats -> output sequence equals input sequence, occupancy never exceeds 2.
